// File: rtl/ring_osc_pkg.sv
// Shared types and default constants for the ring-oscillator PLL loop controller.
package ring_osc_pkg;

  localparam int unsigned COARSE_W_DEF   = 3;
  localparam int unsigned FINE_W_DEF     = 8;
  localparam int unsigned CAL_WIN_DEF    = 64;
  localparam int unsigned GAIN_SHIFT_DEF = 2;
  localparam int unsigned LOCK_WIN_DEF   = 2;
  localparam int unsigned LOCK_CNT_DEF   = 16;

  // Lock is dropped only when |err| exceeds this multiple of the lock window.
  localparam int unsigned UNLOCK_MULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COARSE = 2'd1,
    FINE   = 2'd2,
    LOCKED = 2'd3
  } state_e;

endpackage

// File: rtl/ring_osc_loop_ctrl_pfd_sync.sv
// Two-flop synchronizers for the PFD up/down pulses and for reset release.
module pfd_sync (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_up,
  input  logic i_down,
  output logic o_rst_n,
  output logic o_up_s,
  output logic o_down_s
);

  logic r_rst_meta;
  logic r_rst_sync;
  logic r_up_meta;
  logic r_up_s;
  logic r_down_meta;
  logic r_down_s;

  // Reset asserts asynchronously, releases after two clk edges.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_up_meta   <= 1'b0;
      r_up_s      <= 1'b0;
      r_down_meta <= 1'b0;
      r_down_s    <= 1'b0;
    end else begin
      r_up_meta   <= i_up;
      r_up_s      <= r_up_meta;
      r_down_meta <= i_down;
      r_down_s    <= r_down_meta;
    end
  end

  assign o_rst_n  = r_rst_sync;
  assign o_up_s   = r_up_s;
  assign o_down_s = r_down_s;

endmodule

// File: rtl/ring_osc_loop_ctrl.sv
// Ring-oscillator PLL loop controller: SAR coarse tap calibration, then
// integrating fine-code loop with lock detection.
module ring_osc_loop_ctrl
  import ring_osc_pkg::*;
#(
  parameter int unsigned COARSE_W   = COARSE_W_DEF,
  parameter int unsigned FINE_W     = FINE_W_DEF,
  parameter int unsigned CAL_WIN    = CAL_WIN_DEF,
  parameter int unsigned GAIN_SHIFT = GAIN_SHIFT_DEF,
  parameter int unsigned LOCK_WIN   = LOCK_WIN_DEF,
  parameter int unsigned LOCK_CNT   = LOCK_CNT_DEF
) (
  input  logic                clk,
  input  logic                delay_up_reset,
  input  logic                enable,
  input  logic                start,
  input  logic                up,
  input  logic                down,
  output logic                pfd_en,
  output logic [COARSE_W-1:0] coarse_sel,
  output logic [FINE_W-1:0]   fine_code,
  output logic                busy,
  output logic                locked
);

  localparam int unsigned ERR_W  = $clog2(CAL_WIN) + 2;
  localparam int unsigned WCNT_W = $clog2(CAL_WIN);
  localparam int unsigned IDX_W  = (COARSE_W > 1) ? $clog2(COARSE_W) : 1;
  localparam int unsigned LCNT_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned SUM_W  = FINE_W + 2;

  localparam logic [COARSE_W-1:0] COARSE_INIT = COARSE_W'(1) << (COARSE_W - 1);
  localparam logic [FINE_W-1:0]   FINE_INIT   = FINE_W'(1) << (FINE_W - 1);

  logic w_rst_n;
  logic w_up_s;
  logic w_down_s;

  pfd_sync u_sync (
    .clk      (clk),
    .i_rst_n  (delay_up_reset),
    .i_up     (up),
    .i_down   (down),
    .o_rst_n  (w_rst_n),
    .o_up_s   (w_up_s),
    .o_down_s (w_down_s)
  );

  state_e                   r_state;
  logic [WCNT_W-1:0]        r_wcnt;
  logic signed [ERR_W-1:0]  r_err;
  logic [IDX_W-1:0]         r_idx;
  logic [LCNT_W-1:0]        r_lcnt;

  logic signed [ERR_W-1:0]  w_contrib;
  logic signed [ERR_W-1:0]  w_err_sum;
  logic signed [ERR_W-1:0]  w_err_shift;
  logic [ERR_W-1:0]         w_err_abs;
  logic signed [SUM_W-1:0]  w_fine_sum;
  logic [FINE_W-1:0]        w_fine_next;
  logic                     w_win_end;
  logic                     w_err_pos;
  logic                     w_in_tol;
  logic                     w_unlock;

  // Window error includes the current cycle so the window-end decision sees all CAL_WIN samples.
  assign w_contrib   = (w_up_s & ~w_down_s) ? ERR_W'(1) :
                       (w_down_s & ~w_up_s) ? '1 : '0;
  assign w_err_sum   = r_err + w_contrib;
  assign w_win_end   = (r_wcnt == WCNT_W'(CAL_WIN - 1));
  assign w_err_pos   = !w_err_sum[ERR_W-1] && (w_err_sum != '0);
  assign w_err_abs   = w_err_sum[ERR_W-1] ? ERR_W'(-w_err_sum) : ERR_W'(w_err_sum);
  assign w_in_tol    = (w_err_abs <= ERR_W'(LOCK_WIN));
  assign w_unlock    = (w_err_abs > ERR_W'(UNLOCK_MULT * LOCK_WIN));
  assign w_err_shift = w_err_sum >>> GAIN_SHIFT;
  assign w_fine_sum  = $signed({2'b00, fine_code}) + SUM_W'(w_err_shift);
  // Saturate: negative -> 0, overflow past FINE_W bits -> all ones.
  assign w_fine_next = w_fine_sum[SUM_W-1] ? '0 :
                       w_fine_sum[SUM_W-2] ? '1 : w_fine_sum[FINE_W-1:0];

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= IDLE;
      r_wcnt     <= '0;
      r_err      <= '0;
      r_idx      <= '0;
      r_lcnt     <= '0;
      pfd_en     <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      coarse_sel <= COARSE_INIT;
      fine_code  <= FINE_INIT;
    end else if (!enable) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_err   <= '0;
      r_lcnt  <= '0;
      pfd_en  <= 1'b0;
      busy    <= 1'b0;
      locked  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= COARSE;
            r_wcnt     <= '0;
            r_err      <= '0;
            r_lcnt     <= '0;
            r_idx      <= IDX_W'(COARSE_W - 1);
            pfd_en     <= 1'b1;
            busy       <= 1'b1;
            coarse_sel <= COARSE_INIT;
            fine_code  <= FINE_INIT;
          end
        end
        COARSE, FINE, LOCKED: begin
          r_wcnt <= w_win_end ? '0 : WCNT_W'(r_wcnt + 1'b1);
          r_err  <= w_win_end ? '0 : w_err_sum;
          if (w_win_end) begin
            case (r_state)
              COARSE: begin
                if (!w_err_pos) coarse_sel[r_idx] <= 1'b0;
                if (r_idx != '0) begin
                  coarse_sel[IDX_W'(r_idx - 1'b1)] <= 1'b1;
                  r_idx <= IDX_W'(r_idx - 1'b1);
                end else begin
                  r_state <= FINE;
                end
              end
              FINE: begin
                fine_code <= w_fine_next;
                if (!w_in_tol) begin
                  r_lcnt <= '0;
                end else if (r_lcnt == LCNT_W'(LOCK_CNT - 1)) begin
                  r_lcnt  <= LCNT_W'(LOCK_CNT);
                  r_state <= LOCKED;
                  locked  <= 1'b1;
                end else begin
                  r_lcnt <= LCNT_W'(r_lcnt + 1'b1);
                end
              end
              default: begin
                fine_code <= w_fine_next;
                if (w_unlock) begin
                  r_lcnt  <= '0;
                  r_state <= FINE;
                  locked  <= 1'b0;
                end
              end
            endcase
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_osc_loop_ctrl.sv
// Scoreboard bench for ring_osc_loop_ctrl: expected output changes are queued
// with their cycle stamps and matched by an independent monitor.
module tb_ring_osc_loop_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       start;
  logic       up;
  logic       down;
  logic       pfd_en;
  logic       busy;
  logic       locked;
  logic [2:0] coarse_sel;
  logic [7:0] fine_code;

  typedef struct packed {
    logic [31:0] cyc;
    logic        pfd;
    logic        bsy;
    logic        lck;
    logic [2:0]  crs;
    logic [7:0]  fin;
  } obs_t;

  obs_t sb[$];
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   e0    = 0;

  ring_osc_loop_ctrl dut (
    .clk            (clk),
    .delay_up_reset (rst_n),
    .enable         (enable),
    .start          (start),
    .up             (up),
    .down           (down),
    .pfd_en         (pfd_en),
    .coarse_sel     (coarse_sel),
    .fine_code      (fine_code),
    .busy           (busy),
    .locked         (locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t mk(input int c, input logic p, input logic b, input logic l,
                              input logic [2:0] cr, input logic [7:0] f);
    obs_t o;
    o.cyc = 32'(c);
    o.pfd = p;
    o.bsy = b;
    o.lck = l;
    o.crs = cr;
    o.fin = f;
    return o;
  endfunction

  function automatic logic [13:0] fields(input obs_t o);
    return {o.pfd, o.bsy, o.lck, o.crs, o.fin};
  endfunction

  // Monitor: every observed output change must match the next queued expectation.
  initial begin
    obs_t prev;
    obs_t cur;
    obs_t exp_o;
    prev = mk(0, 1'b0, 1'b0, 1'b0, 3'd4, 8'd128);
    forever begin
      @(negedge clk);
      cur = mk(cyc, pfd_en, busy, locked, coarse_sel, fine_code);
      if (fields(cur) != fields(prev)) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change: got cyc=%0d pfd_en=%b busy=%b locked=%b coarse=%0d fine=%0d, expected no change",
                   cur.cyc, cur.pfd, cur.bsy, cur.lck, cur.crs, cur.fin);
        end else begin
          exp_o = sb.pop_front();
          if (cur != exp_o) begin
            n_err++;
            $display("FAIL sb_event: got cyc=%0d pfd_en=%b busy=%b locked=%b coarse=%0d fine=%0d, expected cyc=%0d pfd_en=%b busy=%b locked=%b coarse=%0d fine=%0d",
                     cur.cyc, cur.pfd, cur.bsy, cur.lck, cur.crs, cur.fin,
                     exp_o.cyc, exp_o.pfd, exp_o.bsy, exp_o.lck, exp_o.crs, exp_o.fin);
          end
        end
      end
      prev = cur;
    end
  end

  task automatic expect_at(input int c, input logic p, input logic b, input logic l,
                           input logic [2:0] cr, input logic [7:0] f);
    sb.push_back(mk(c, p, b, l, cr, f));
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_to(input int t);
    if (t <= cyc) begin
      n_chk++;
      n_err++;
      $display("FAIL schedule: got cyc=%0d, required before %0d", cyc, t);
    end
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_start();
    expect_at(cyc + 1, 1'b1, 1'b1, 1'b0, 3'd4, 8'd128);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic check_reset_vals(input string nm);
    n_chk++;
    if ({pfd_en, busy, locked, coarse_sel, fine_code} !== {1'b0, 1'b0, 1'b0, 3'd4, 8'd128}) begin
      n_err++;
      $display("FAIL %s: got pfd_en=%b busy=%b locked=%b coarse=%0d fine=%0d, expected 0 0 0 4 128",
               nm, pfd_en, busy, locked, coarse_sel, fine_code);
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    enable = 1'b0;
    start  = 1'b0;
    up     = 1'b0;
    down   = 1'b0;
    #1 rst_n = 1'b0;
    ticks(2);
    check_reset_vals("por_reset");
    ticks(1);
    rst_n = 1'b1;
    ticks(5);

    // Up held high: SAR keeps every bit, fine code ramps +16 per window and saturates.
    enable = 1'b1;
    up     = 1'b1;
    ticks(3);
    do_start();
    expect_at(e0 + 64,  1'b1, 1'b1, 1'b0, 3'd6, 8'd128);
    expect_at(e0 + 128, 1'b1, 1'b1, 1'b0, 3'd7, 8'd128);
    for (int k = 1; k <= 8; k++)
      expect_at(e0 + 192 + 64 * k, 1'b1, 1'b1, 1'b0, 3'd7, (k == 8) ? 8'd255 : 8'(128 + 16 * k));
    tick_to(e0 + 720);
    start = 1'b1;
    ticks(1);
    start = 1'b0;
    tick_to(e0 + 800);
    expect_at(cyc + 1, 1'b0, 1'b0, 1'b0, 3'd7, 8'd255);
    enable = 1'b0;
    ticks(5);
    start = 1'b1;
    ticks(1);
    start = 1'b0;
    ticks(5);

    // Down held high through coarse, then balanced -> lock, one down window -> unlock, alternating -> relock.
    up     = 1'b0;
    down   = 1'b1;
    enable = 1'b1;
    ticks(3);
    do_start();
    expect_at(e0 + 64,  1'b1, 1'b1, 1'b0, 3'd2, 8'd128);
    expect_at(e0 + 128, 1'b1, 1'b1, 1'b0, 3'd1, 8'd128);
    expect_at(e0 + 192, 1'b1, 1'b1, 1'b0, 3'd0, 8'd128);
    tick_to(e0 + 190);
    up = 1'b1;
    expect_at(e0 + 1216, 1'b1, 1'b1, 1'b1, 3'd0, 8'd128);
    tick_to(e0 + 1214);
    up = 1'b0;
    expect_at(e0 + 1280, 1'b1, 1'b1, 1'b0, 3'd0, 8'd112);
    expect_at(e0 + 2304, 1'b1, 1'b1, 1'b1, 3'd0, 8'd112);
    tick_to(e0 + 1278);
    up   = 1'b1;
    down = 1'b0;
    while (cyc < e0 + 2310) begin
      @(negedge clk);
      up   = ~up;
      down = ~down;
    end
    expect_at(cyc + 1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd112);
    enable = 1'b0;
    ticks(3);

    // Reset asserted mid-coarse: outputs return to reset values without waiting for clk.
    up     = 1'b1;
    down   = 1'b0;
    enable = 1'b1;
    ticks(3);
    do_start();
    expect_at(e0 + 64, 1'b1, 1'b1, 1'b0, 3'd6, 8'd128);
    tick_to(e0 + 100);
    expect_at(e0 + 101, 1'b0, 1'b0, 1'b0, 3'd4, 8'd128);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_mid_coarse");
    ticks(3);
    rst_n = 1'b1;
    ticks(6);

    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL pending_events: got %0d unmatched expectations, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ring_osc_loop_ctrl.md
# ring_osc_loop_ctrl

Digital loop controller for the ring-oscillator PLL. It samples the up/down pulses from the phase-frequency detector and runs a successive-approximation coarse calibration of the ring tap select. It then integrates phase error into a fine delay code and reports lock. It sits between the PFD and the ring oscillator's coarse/fine control inputs, and gates the PFD through `pfd_en`.

## Interface
Parameters:
- COARSE_W, 3, coarse tap-select width
- FINE_W, 8, fine delay code width
- CAL_WIN, 64, error-integration window length in clk cycles
- GAIN_SHIFT, 2, arithmetic right shift applied to window error before the fine update
- LOCK_WIN, 2, lock window: lock tolerance on |err|
- LOCK_CNT, 16, consecutive in-tolerance windows required to assert lock

Ports:
- clk  in  1  sampling clock, faster than ref
- delay_up_reset  in  1  reset delay_up_reset, asynchronous, active-low
- enable  in  1  level; low forces IDLE
- start  in  1  single-cycle pulse, begins acquisition
- up  in  1  PFD up output, asynchronous to clk
- down  in  1  PFD down output, asynchronous to clk
- pfd_en  out  1  enables PFD clocking
- coarse_sel  out  COARSE_W  ring tap select
- fine_code  out  FINE_W  fine delay code
- busy  out  1  high in COARSE, FINE and LOCKED
- locked  out  1  high only in LOCKED

## Operation
- up and down each pass through a 2-flop synchronizer. Per-cycle error contribution:
  - +1 if up_s & ~down_s
  - -1 if down_s & ~up_s
  - 0 otherwise, including both high
- err is a signed accumulator, $clog2(CAL_WIN)+2 bits. The window counter runs 0..CAL_WIN-1. At count CAL_WIN-1 ("window end"), err includes that cycle's contribution, is consumed, and is cleared for the next window.
- States:
  - IDLE: pfd_en=0; codes held.
  - start & enable: coarse_sel=1<<(COARSE_W-1), fine_code=2^(FINE_W-1), bit index i=COARSE_W-1, go to COARSE.
  - start while busy: ignored.
- COARSE, SAR MSB-first:
  - At each window end, keep bit i if err>0, else clear it.
  - If i>0, set bit i-1 and decrement i.
  - After the window for i=0, go to FINE.
- FINE, at each window end:
  - fine_code <= clamp(fine_code + (err>>>GAIN_SHIFT), 0, 2^FINE_W-1), computed in FINE_W+2 signed bits.
  - If |err|<=LOCK_WIN, increment the lock counter; else clear it.
  - When the counter reaches LOCK_CNT, go to LOCKED.
- LOCKED: same fine update. If |err|>4*LOCK_WIN, go to FINE and clear the lock counter.
- enable=0 in any state: IDLE next cycle. The window counter, err and lock counter are cleared.
- Reset values: coarse_sel=2^(COARSE_W-1), fine_code=2^(FINE_W-1); pfd_en, busy and locked are 0; state IDLE; all counters 0.

## Timing
- All outputs are registered.
- Input to err latency: 3 cycles (2 synchronizer stages + accumulate).
- coarse_sel/fine_code update on the cycle after window end.
- locked rises or falls in the same cycle as the state change. The state change is the cycle after the qualifying window end.
- pfd_en and busy rise the cycle after start and fall the cycle after enable drops.
- Coarse calibration takes exactly COARSE_W*CAL_WIN cycles.
- Reset mid-operation: all outputs go to their reset values immediately. Deassertion is synchronized to clk inside the block (2-flop release).

## Structure
- Package ring_osc_pkg holds:
  - the state enum (IDLE, COARSE, FINE, LOCKED)
  - default parameter constants
  - the unlock multiplier, 4
- Sub-module pfd_sync: 2-flop synchronizer for up/down, plus the reset release synchronizer.
- The error accumulator, SAR and FSM stay in ring_osc_loop_ctrl.

## Test plan
All scenarios use default parameters.
- Reset mid-COARSE:
  - Stimulus: delay_up_reset low.
  - Required: immediately coarse_sel=4, fine_code=128, pfd_en=0, busy=0, locked=0.
- up held high, start:
  - Required: coarse_sel goes 4→6→7 at the window ends; FINE is entered at cycle 192 + latency.
  - With down held high instead: coarse_sel goes 4→2→1→0.
- FINE with up constant:
  - err=+64 per window, +16 per window.
  - fine_code goes 128→144→…→240, then saturates at 255. There is no wrap.
- Balanced up/down (both high or alternating, err=0):
  - locked asserts one cycle after the 16th FINE window end.
  - fine_code holds at 128.
- LOCKED, then one window of down constant (err=-64):
  - locked=0 the next cycle; state FINE; fine_code decreases by 16.
- enable dropped mid-FINE:
  - IDLE next cycle; pfd_en=0; codes held.
  - A start with enable=0 is ignored.
  - A start with enable=1 reinitializes coarse_sel=4 and fine_code=128.
